// File: rtl/tx_framer_if.sv
// tx_framer_if: stream-source and byte-sink signals of the frame transmitter.
// The master modport is the framer side. It pulls words from the stream source
// and drives the outgoing byte channel. The slave modport is the environment
// side, which holds the message source and the byte sink.
interface tx_framer_if;
    logic [31:0] strm_data;
    logic [7:0]  strm_count;
    logic [3:0]  strm_id;
    logic        strm_avail;
    logic        strm_pull;
    logic [3:0]  send_id;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  strm_data,
        input  strm_count,
        input  strm_id,
        input  strm_avail,
        input  tx_ready,
        output strm_pull,
        output send_id,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output strm_data,
        output strm_count,
        output strm_id,
        output strm_avail,
        output tx_ready,
        input  strm_pull,
        input  send_id,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/tx_framer.sv
// tx_framer: turns a pending stream message into a byte frame.
// Frame layout: 0xA5, {4'h0, id}, word count, then each 32-bit word as four
// bytes, least significant byte first.
// Optional feature macro TX_FRAMER_CRC_EN: when defined, one CRC-8 byte is
// appended. It uses poly 0x07 and init 0x00, and covers the ID, COUNT and DATA
// bytes. When the macro is undefined, the CRC state and logic are removed.
// All outputs are registered. The reset is asynchronous and active-low.
module tx_framer (
    input  logic          clk,
    input  logic          rst_n,
    tx_framer_if.master   bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] ID    = 3'd2;
    localparam logic [2:0] COUNT = 3'd3;
    localparam logic [2:0] LOAD  = 3'd4;
    localparam logic [2:0] DATA  = 3'd5;
`ifdef TX_FRAMER_CRC_EN
    localparam logic [2:0] CRC   = 3'd6;
`endif

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic [2:0]  state_q,  state_n;
    logic [3:0]  id_q,     id_n;
    logic [7:0]  count_q,  count_n;
    logic [31:0] shift_q,  shift_n;
    logic [1:0]  idx_q,    idx_n;
    logic [7:0]  data_q,   data_n;
    logic        valid_q,  valid_n;
    logic        pull_q,   pull_n;
    logic        transfer;

`ifdef TX_FRAMER_CRC_EN
    logic [7:0]  crc_q, crc_n;
    logic [7:0]  crc_upd;

    // Advances the CRC-8 register by one whole byte (MSB first, poly 0x07)
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // CRC value including the byte currently on tx_data, used on its transfer
    always_comb begin
        crc_upd = crc8_next(crc_q, data_q);
    end
`endif

    assign transfer = valid_q & bus.tx_ready;

    // Next-state and next-output logic; every output is set for the state being entered
    always_comb begin
        state_n = state_q;
        id_n    = id_q;
        count_n = count_q;
        shift_n = shift_q;
        idx_n   = idx_q;
        data_n  = data_q;
        valid_n = valid_q;
        pull_n  = 1'b0;
`ifdef TX_FRAMER_CRC_EN
        crc_n   = crc_q;
`endif

        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                if (bus.strm_avail) begin
                    id_n    = bus.strm_id;
                    count_n = bus.strm_count;
                    data_n  = SYNC_BYTE;
                    valid_n = 1'b1;
                    state_n = SYNC;
`ifdef TX_FRAMER_CRC_EN
                    crc_n   = 8'h00;
`endif
                end
            end

            SYNC: begin
                if (transfer) begin
                    data_n  = {4'h0, id_q};
                    state_n = ID;
                end
            end

            ID: begin
                if (transfer) begin
                    data_n  = count_q;
                    state_n = COUNT;
`ifdef TX_FRAMER_CRC_EN
                    crc_n   = crc_upd;
`endif
                end
            end

            COUNT: begin
                if (transfer) begin
`ifdef TX_FRAMER_CRC_EN
                    crc_n = crc_upd;
`endif
                    if (count_q != 8'd0) begin
                        valid_n = 1'b0;
                        pull_n  = 1'b1;
                        state_n = LOAD;
                    end else begin
`ifdef TX_FRAMER_CRC_EN
                        data_n  = crc_upd;
                        state_n = CRC;
`else
                        valid_n = 1'b0;
                        state_n = IDLE;
`endif
                    end
                end
            end

            LOAD: begin
                // One cycle only: take the word, present its low byte next
                shift_n = bus.strm_data;
                data_n  = bus.strm_data[7:0];
                count_n = count_q - 8'd1;
                idx_n   = 2'd0;
                valid_n = 1'b1;
                state_n = DATA;
            end

            DATA: begin
                if (transfer) begin
`ifdef TX_FRAMER_CRC_EN
                    crc_n = crc_upd;
`endif
                    if (idx_q == 2'd3) begin
                        if (count_q != 8'd0) begin
                            valid_n = 1'b0;
                            pull_n  = 1'b1;
                            state_n = LOAD;
                        end else begin
`ifdef TX_FRAMER_CRC_EN
                            data_n  = crc_upd;
                            state_n = CRC;
`else
                            valid_n = 1'b0;
                            state_n = IDLE;
`endif
                        end
                    end else begin
                        // Rotate so the next byte moves into [7:0]; bits [15:8] are about to be sent
                        shift_n = {shift_q[7:0], shift_q[31:8]};
                        data_n  = shift_q[15:8];
                        idx_n   = idx_q + 2'd1;
                    end
                end
            end

`ifdef TX_FRAMER_CRC_EN
            CRC: begin
                if (transfer) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
`endif

            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Frame context: stream id, remaining word count, word shifter and byte index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= 4'h0;
            count_q <= 8'h00;
            shift_q <= 32'h0000_0000;
            idx_q   <= 2'd0;
        end else begin
            id_q    <= id_n;
            count_q <= count_n;
            shift_q <= shift_n;
            idx_q   <= idx_n;
        end
    end

    // Registered byte channel and pull strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            pull_q  <= 1'b0;
        end else begin
            data_q  <= data_n;
            valid_q <= valid_n;
            pull_q  <= pull_n;
        end
    end

`ifdef TX_FRAMER_CRC_EN
    // Running CRC over ID, COUNT and DATA bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_n;
        end
    end
`endif

    assign bus.send_id   = id_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_valid  = valid_q;
    assign bus.strm_pull = pull_q;

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: randomized self-checking bench for tx_framer.
// Expected frames are built from the frame layout. When TX_FRAMER_CRC_EN is
// defined, the expected CRC comes from polynomial long division, and the bench
// compares the received byte stream, pull pulses, send_id and stall behaviour.
module tb_tx_framer;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    tx_framer_if bus ();

    tx_framer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] src_words [256];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_words();
        for (int i = 0; i < 256; i++) src_words[i] = $urandom;
    endtask

    // CRC as remainder of (message * x^8) divided by x^8 + x^2 + x + 1
    function automatic logic [7:0] ref_crc();
        logic [8:0] rem;
        rem = 9'h000;
        for (int i = 1; i < exp_q.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                rem = {rem[7:0], exp_q[i][b]};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        for (int b = 0; b < 8; b++) begin
            rem = {rem[7:0], 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    task automatic build_expected(input logic [3:0] id, input logic [7:0] count);
        logic [7:0] crc;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back({4'h0, id});
        exp_q.push_back(count);
        for (int w = 0; w < int'(count); w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(src_words[w][8*b +: 8]);
        crc = ref_crc();
`ifdef TX_FRAMER_CRC_EN
        exp_q.push_back(crc);
`endif
    endtask

    // Runs one frame from IDLE; mode 0 ready=1, 1 toggling, 2 random; abort_at>=0 resets mid-frame
    task automatic applyStimulus(input logic [3:0] id, input logic [7:0] count, input int mode,
                                 input logic keep_avail, input logic [3:0] next_id,
                                 input int abort_at, input string name);
        int         sample    = 0;
        int         pulls     = 0;
        int         stall_bad = 0;
        int         id_bad    = 0;
        int         order_bad = 0;
        int         byte_bad  = 0;
        logic       started   = 1'b0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       done      = 1'b0;

        build_expected(id, count);
        got_q.delete();

        while (!done && sample < 20000) begin
            @(negedge clk);
            bus.strm_avail = started ? keep_avail : 1'b1;
            bus.strm_id    = started ? next_id : id;
            bus.strm_count = started ? 8'($urandom) : count;
            bus.strm_data  = (pulls < int'(count)) ? src_words[pulls] : $urandom;
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = (sample % 2 == 0);
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (sample == 0) checkOutput({name, "_idle_valid"}, bus.tx_valid, 1'b0);
            if (sample == 1) begin
                checkOutput({name, "_latency_valid"}, bus.tx_valid, 1'b1);
                checkOutput({name, "_latency_sync"}, bus.tx_data, 8'hA5);
            end
            if (bus.tx_valid === 1'b1) started = 1'b1;
            if (started && bus.send_id !== id) id_bad++;
            if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_bad++;
            prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
            prev_data  = bus.tx_data;
            if (bus.strm_pull === 1'b1) begin
                if (got_q.size() != 3 + 4 * pulls) order_bad++;
                pulls++;
            end
            if (abort_at >= 0 && got_q.size() == abort_at && bus.tx_valid === 1'b1) begin
                checkOutput({name, "_pre_reset_byte"}, bus.tx_data, exp_q[abort_at]);
                #1 rst_n = 1'b0;
                #1;
                checkOutput({name, "_rst_valid"}, bus.tx_valid, 1'b0);
                checkOutput({name, "_rst_data"}, bus.tx_data, 8'h00);
                checkOutput({name, "_rst_pull"}, bus.strm_pull, 1'b0);
                checkOutput({name, "_rst_send_id"}, bus.send_id, 4'h0);
                return;
            end
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                got_q.push_back(bus.tx_data);
                if (got_q.size() >= exp_q.size()) done = 1'b1;
            end
            sample++;
        end

        if (!done) checkOutput({name, "_timeout"}, 1, 0);
        @(posedge clk);
        #1;
        checkOutput({name, "_end_idle_valid"}, bus.tx_valid, 1'b0);
        checkOutput({name, "_end_idle_pull"}, bus.strm_pull, 1'b0);

        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) byte_bad++;
        checkOutput({name, "_length"}, got_q.size(), exp_q.size());
        checkOutput({name, "_bytes_wrong"}, byte_bad, 0);
        checkOutput({name, "_pulls"}, pulls, count);
        checkOutput({name, "_pull_order"}, order_bad, 0);
        checkOutput({name, "_send_id"}, id_bad, 0);
        checkOutput({name, "_stall_hold"}, stall_bad, 0);
    endtask

    // Directed scenarios followed by random frames
    initial begin
        int idle_bad;
        rst_n          = 1'b0;
        bus.strm_data  = 32'h0;
        bus.strm_count = 8'h0;
        bus.strm_id    = 4'h0;
        bus.strm_avail = 1'b0;
        bus.tx_ready   = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("reset_valid", bus.tx_valid, 1'b0);
        checkOutput("reset_data", bus.tx_data, 8'h00);
        checkOutput("reset_pull", bus.strm_pull, 1'b0);
        checkOutput("reset_send_id", bus.send_id, 4'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        src_words[0] = 32'h1234_5678;
        applyStimulus(4'd1, 8'd1, 0, 1'b0, 4'd0, -1, "single_word");

        fill_words();
        applyStimulus(4'd0, 8'd0, 0, 1'b0, 4'd0, -1, "empty");

        fill_words();
        applyStimulus(4'd5, 8'd2, 1, 1'b0, 4'd0, -1, "toggle_ready");

        fill_words();
        applyStimulus(4'd1, 8'd1, 0, 1'b1, 4'd0, -1, "id_change_a");
        fill_words();
        applyStimulus(4'd0, 8'd1, 0, 1'b0, 4'd0, -1, "id_change_b");

        fill_words();
        applyStimulus(4'd7, 8'd3, 0, 1'b0, 4'd0, 4, "mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.strm_avail = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_bad = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.strm_pull !== 1'b0 || bus.tx_valid !== 1'b0) idle_bad++;
        end
        checkOutput("post_reset_quiet", idle_bad, 0);
        fill_words();
        applyStimulus(4'd2, 8'd1, 0, 1'b0, 4'd0, -1, "after_reset");

        fill_words();
        applyStimulus(4'd9, 8'd255, 0, 1'b0, 4'd0, -1, "max_count");

        for (int n = 0; n < 10; n++) begin
            fill_words();
            applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 12)),
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), -1, $sformatf("random%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
